// File: rtl/reg_scratch_responder_if.sv
// Register-bus request/response bundle between a reg master and the scratch responder.
// Signal names keep the bus-side naming used throughout the RegMap fabric.
interface reg_scratch_responder_if;
    logic [63:0] reg_addr_i;
    logic        reg_write_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_valid_i;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic        reg_ready_o;

    modport slave (
        input  reg_addr_i,
        input  reg_write_i,
        input  reg_wdata_i,
        input  reg_wstrb_i,
        input  reg_valid_i,
        output reg_rdata_o,
        output reg_error_o,
        output reg_ready_o
    );

    modport master (
        output reg_addr_i,
        output reg_write_i,
        output reg_wdata_i,
        output reg_wstrb_i,
        output reg_valid_i,
        input  reg_rdata_o,
        input  reg_error_o,
        input  reg_ready_o
    );
endinterface

// File: rtl/reg_scratch_responder.sv
// Scratch register file on the reg bus: word storage with byte strobes,
// programmable wait states and decode errors for out-of-window or misaligned accesses.
module reg_scratch_responder #(
    parameter logic [63:0] BaseAddr   = 64'h0000_0000_0001_5000,
    parameter int unsigned NumWords   = 16,
    parameter int unsigned WaitCycles = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    reg_scratch_responder_if.slave  bus
);
    localparam int unsigned IDX_W     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CNT_W     = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;
    localparam int unsigned CNT_INIT  = (WaitCycles > 0) ? WaitCycles - 1 : 0;
    localparam logic [63:0] WIN_BYTES = 64'(NumWords) * 64'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               accept;
    logic               write_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         wstrb_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               err_reg;
    logic [31:0]        mem_reg [NumWords];

    // Decode is done on the incoming request and only its result is latched.
    logic [63:0]        req_offset;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    assign req_offset = bus.reg_addr_i - BaseAddr;
    assign req_err    = (bus.reg_addr_i < BaseAddr) || (req_offset >= WIN_BYTES) ||
                        (bus.reg_addr_i[1:0] != 2'b00);
    assign req_idx    = req_offset[IDX_W+1:2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.reg_valid_i) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(CNT_INIT);
                    state_next = (WaitCycles > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= bus.reg_write_i;
                wdata_reg <= bus.reg_wdata_i;
                wstrb_reg <= bus.reg_wstrb_i;
                idx_reg   <= req_idx;
                err_reg   <= req_err;
            end
        end
    end

    // A write lands on the edge that ends RESP, so the next transaction sees it.
    logic commit;
    assign commit = (state_reg == S_RESP) && write_reg && !err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NumWords; gi++) begin : g_word
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    mem_reg[gi] <= '0;
                end else if (commit && (idx_reg == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_reg[b]) begin
                            mem_reg[gi][8*b +: 8] <= wdata_reg[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    logic resp;
    assign resp            = (state_reg == S_RESP);
    assign bus.reg_ready_o = resp;
    assign bus.reg_error_o = resp && err_reg;
    assign bus.reg_rdata_o = (resp && !write_reg && !err_reg) ? mem_reg[idx_reg] : 32'h0;
endmodule

// File: tb/tb_reg_scratch_responder.sv
// Scoreboard bench for the scratch responder: two instances (2 and 0 wait states),
// directed plus randomized traffic checked against a word-array reference model.
module tb_reg_scratch_responder;
    localparam logic [63:0] BASE = 64'h0000_0000_0001_5000;
    localparam int          NW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_scratch_responder_if bus_a();
    reg_scratch_responder_if bus_b();

    reg_scratch_responder #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a.slave)
    );
    reg_scratch_responder #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] model [2][NW];
    int          total = 0;
    int          bad   = 0;

    function automatic bit in_window(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(NW * 4)) && (a % 4 == 0);
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < NW; i++) model[w][i] = 32'h0;
    endtask

    task automatic set_req(input int w, input bit v, input logic [63:0] a, input bit wr,
                           input logic [31:0] d, input logic [3:0] s);
        if (w == 0) begin
            bus_a.reg_valid_i = v; bus_a.reg_addr_i = a; bus_a.reg_write_i = wr;
            bus_a.reg_wdata_i = d; bus_a.reg_wstrb_i = s;
        end else begin
            bus_b.reg_valid_i = v; bus_b.reg_addr_i = a; bus_b.reg_write_i = wr;
            bus_b.reg_wdata_i = d; bus_b.reg_wstrb_i = s;
        end
    endtask

    // Called at #1 after a rising edge with the target instance idle.
    task automatic issue(input int w, input logic [63:0] a, input bit wr, input logic [31:0] d,
                         input logic [3:0] s, input bit drop, input bit hold);
        exp_t e;
        bit   err;
        int   idx;
        bit   got;
        err     = !in_window(a);
        idx     = err ? 0 : int'((a - BASE) / 4);
        e.err   = err;
        e.rdata = (wr || err) ? 32'h0 : model[w][idx];
        e.cyc   = cyc + 1 + ((w == 0) ? 2 : 0);
        if (w == 0) q_a.push_back(e); else q_b.push_back(e);
        set_req(w, 1'b1, a, wr, d, s);
        if (drop) begin
            @(posedge clk); #1;
            set_req(w, 1'b0, {$urandom, $urandom}, ~wr, $urandom, 4'($urandom));
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = (w == 0) ? bus_a.reg_ready_o : bus_b.reg_ready_o;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout dut%0d addr=%h: ready never seen, required within 40 cycles", w, a);
        end
        if (wr && !err)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[w][idx][8*b +: 8] = d[8*b +: 8];
        @(posedge clk); #1;
        if (!hold) set_req(w, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic mon(input int w, input logic rdy, input logic [31:0] rd, input logic er);
        exp_t e;
        int   qs;
        qs = (w == 0) ? q_a.size() : q_b.size();
        if (rdy) begin
            if (qs == 0) begin
                total++; bad++;
                $display("FAIL spurious_ready dut%0d cyc=%0d: ready=1, required 0", w, cyc);
            end else begin
                e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
                total += 3;
                if (rd !== e.rdata) begin
                    bad++;
                    $display("FAIL rdata dut%0d cyc=%0d: got %h required %h", w, cyc, rd, e.rdata);
                end
                if (er !== e.err) begin
                    bad++;
                    $display("FAIL error dut%0d cyc=%0d: got %b required %b", w, cyc, er, e.err);
                end
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL latency dut%0d: ready at cyc %0d required %0d", w, cyc, e.cyc);
                end
            end
        end else begin
            total++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                bad++;
                $display("FAIL idle_out dut%0d cyc=%0d: rdata=%h error=%b required 0/0", w, cyc, rd, er);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus_a.reg_ready_o, bus_a.reg_rdata_o, bus_a.reg_error_o);
            mon(1, bus_b.reg_ready_o, bus_b.reg_rdata_o, bus_b.reg_error_o);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          cur_w;
        int          next_w;
        int          r;
        logic [63:0] a;
        bit          hold;

        clear_model();
        set_req(0, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed traffic on the two-wait-state instance
        issue(0, 64'h15000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b1, 32'h11223344, 4'b0101, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15040, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h14FFC, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15002, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b0);
        issue(0, 64'h15100, 1'b1, 32'hA5A5A5A5, 4'b1111, 1'b0, 1'b0);
        issue(0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b1, 32'h99999999, 4'b0000, 1'b0, 1'b0);
        issue(0, 64'h15004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h15008, 1'b1, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0);
        issue(0, 64'h15000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        issue(0, 64'h15004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        issue(0, 64'h15008, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(0, 64'h1503C, 1'b1, 32'h01020304, 4'b1111, 1'b1, 1'b0);
        issue(0, 64'h1503C, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Zero-wait-state instance, back-to-back writes then reads
        issue(1, 64'h15000, 1'b1, 32'h10101010, 4'b1111, 1'b0, 1'b1);
        issue(1, 64'h15004, 1'b1, 32'h20202020, 4'b1111, 1'b0, 1'b1);
        issue(1, 64'h15008, 1'b1, 32'h30303030, 4'b0011, 1'b0, 1'b1);
        issue(1, 64'h15000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        issue(1, 64'h15004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        issue(1, 64'h15008, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
        issue(1, 64'h15041, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Reset during WAIT of a write: the write must be dropped and storage cleared
        set_req(0, 1'b1, 64'h15008, 1'b1, 32'hCAFEF00D, 4'b1111);
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        repeat (4) begin @(posedge clk); #1; end
        issue(0, 64'h15008, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        issue(1, 64'h15000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Randomized mix across both instances
        cur_w = int'($urandom_range(0, 1));
        for (int i = 0; i < 200; i++) begin
            next_w = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = BASE + 64'(4 * $urandom_range(0, NW - 1));
            else if (r == 7) a = BASE + 64'($urandom_range(0, NW * 4 - 1));
            else if (r == 8) a = BASE + 64'(NW * 4) + 64'(4 * $urandom_range(0, 15));
            else             a = BASE - 64'(4 * $urandom_range(1, 16));
            hold = (i != 199) && (next_w == cur_w) && ($urandom_range(0, 1) == 1);
            issue(cur_w, a, 1'($urandom), $urandom, 4'($urandom),
                  $urandom_range(0, 7) == 0, hold);
            if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            cur_w = next_w;
        end

        set_req(0, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
        set_req(1, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain: pending a=%0d b=%0d, required 0/0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
